// File: rtl/bcd_pkg.sv
//------------------------------------------------------------------------------
// bcd_pkg : shared BCD digit type, constants and conversion helpers
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

package bcd_pkg;

  localparam int         DIGIT_W    = 4;
  localparam logic [3:0] DIGIT_MAX  = 4'd9;
  localparam int         MAX_DIGITS = 16;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  // Callers zero-extend their vector to MAX_DIGITS digits.
  function automatic logic is_bcd(input logic [DIGIT_W*MAX_DIGITS-1:0] v,
                                  input int digits);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits && v[DIGIT_W*i +: DIGIT_W] > DIGIT_MAX) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic [DIGIT_W*MAX_DIGITS-1:0] to_bcd(input int value,
                                                          input int digits);
    logic [DIGIT_W*MAX_DIGITS-1:0] r;
    int v;
    r = '0;
    v = value;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits) begin
        r[DIGIT_W*i +: DIGIT_W] = DIGIT_W'(v % 10);
        v = v / 10;
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_cell.sv
//------------------------------------------------------------------------------
// bcd_digit_cell : one BCD digit stepping +1/-1 with carry/borrow in and out
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_digit_cell
  import bcd_pkg::*;
(
  input  bcd_digit_t d,
  input  logic       up,
  input  logic       cin,
  output bcd_digit_t q,
  output logic       cout
);

  always_comb begin
    q    = d;
    cout = 1'b0;
    if (cin) begin
      if (up) begin
        // >= rather than == so a corrupt digit still rolls back into range
        if (d >= DIGIT_MAX) begin
          q    = '0;
          cout = 1'b1;
        end else begin
          q = d + 4'd1;
        end
      end else begin
        if (d == '0) begin
          q    = DIGIT_MAX;
          cout = 1'b1;
        end else begin
          q = d - 4'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bcd_mod_counter.sv
//------------------------------------------------------------------------------
// bcd_mod_counter : multi-digit BCD modulo counter, up/down, wrap/saturate
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_mod_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int INIT   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  sat,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic [4*DIGITS-1:0]   limit,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  at_limit,
  output logic                  at_zero,
  output logic                  err
);

  localparam int                          c_w        = DIGIT_W * DIGITS;
  localparam logic [DIGIT_W*MAX_DIGITS-1:0] c_init_all = to_bcd(INIT, DIGITS);
  localparam logic [c_w-1:0]              c_init     = c_init_all[c_w-1:0];

  logic [c_w-1:0] r_count;
  logic           r_tc;
  logic           r_err;

  logic [c_w-1:0] w_step;
  logic [DIGITS:0] w_carry;
  logic [c_w-1:0] w_load_clip;
  logic           w_load_ok;
  logic [c_w-1:0] w_count_nxt;
  logic           w_tc_nxt;
  logic           w_err_nxt;

  assign w_carry[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_digit_cell u_cell (
        .d    (r_count[DIGIT_W*gi +: DIGIT_W]),
        .up   (up),
        .cin  (w_carry[gi]),
        .q    (w_step[DIGIT_W*gi +: DIGIT_W]),
        .cout (w_carry[gi+1])
      );
    end
  endgenerate

  assign w_load_ok   = is_bcd((DIGIT_W*MAX_DIGITS)'(load_val), DIGITS);
  assign w_load_clip = (load_val > limit) ? limit : load_val;

  always_comb begin
    w_count_nxt = r_count;
    w_tc_nxt    = 1'b0;
    w_err_nxt   = 1'b0;
    if (load) begin
      if (w_load_ok) w_count_nxt = w_load_clip;
      else           w_err_nxt   = 1'b1;
    end else if (en) begin
      if (up) begin
        // A carry out of the top digit only happens with an illegal limit;
        // treat it like reaching the limit rather than silently rolling over.
        if (r_count < limit && !w_carry[DIGITS]) begin
          w_count_nxt = w_step;
        end else if (!sat) begin
          w_count_nxt = '0;
          w_tc_nxt    = 1'b1;
        end
      end else begin
        if (r_count > limit) begin
          w_count_nxt = limit;
        end else if (r_count != '0) begin
          w_count_nxt = w_step;
        end else if (!sat) begin
          w_count_nxt = limit;
          w_tc_nxt    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= c_init;
      r_tc    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_tc    <= w_tc_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign count    = r_count;
  assign tc       = r_tc;
  assign err      = r_err;
  assign at_limit = (r_count == limit);
  assign at_zero  = (r_count == '0);

endmodule

`default_nettype wire

// File: doc/bcd_mod_counter.md
Name: bcd_mod_counter

Overview:
Parametrised multi-digit decimal modulo counter. The count is held directly as packed BCD digits, so display paths need no divide or modulo logic. Supports a run-time limit, up/down counting, synchronous preload, wrap or saturate mode, and a terminal-count pulse for cascading. It is the general-purpose successor to the fixed two-digit year/minute/second counters used in the clock and timer datapaths.

Parameters:
DIGITS, 2, number of BCD digits; count width is 4*DIGITS
INIT, 0, reset value as an integer; must be 0..(10^DIGITS - 1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  count enable; one step per clk while high
up  in  1  1 = count up, 0 = count down
sat  in  1  1 = saturate at the ends, 0 = wrap
load  in  1  synchronous preload strobe
load_val  in  4*DIGITS  BCD preload value
limit  in  4*DIGITS  BCD terminal value (the count range is 0..limit)
count  out  4*DIGITS  BCD count; digit 0 is in bits [3:0]
tc  out  1  registered one-cycle terminal-count pulse
at_limit  out  1  combinational: count == limit
at_zero  out  1  combinational: count == 0
err  out  1  registered one-cycle pulse on a rejected load

Behaviour:
- Reset: rst high asynchronously forces count = BCD(INIT), tc = 0, err = 0. The reset value is a constant; there is no input-dependent reset value.
- Priority per rising edge: load > en > hold.
- load=1:
  - load_val has every digit <= 9: count <= min(load_val, limit), tc <= 0.
  - any digit of load_val > 9: count holds, err <= 1 for one cycle.
- en=1, up=1:
  - count < limit: count <= count + 1, with decimal carry across digits (9 -> 0, carry into the next digit).
  - count >= limit, sat=0: count <= 0 and tc <= 1.
  - count >= limit, sat=1: count holds and tc <= 0.
- en=1, up=0:
  - count > limit: count <= limit.
  - 0 < count <= limit: count <= count - 1, with decimal borrow (0 -> 9, borrow from the next digit).
  - count == 0, sat=0: count <= limit and tc <= 1.
  - count == 0, sat=1: count holds.
- tc is high only in the cycle after the wrapping edge; it is 0 on every other edge, including edges with en=0.
- Latency: count and tc are valid 1 cycle after the qualifying edge. at_limit and at_zero follow count combinationally.
- Limit is sampled every edge, with no shadow register. If limit is lowered below the current count, the next up step wraps to 0 (with tc) and the next down step snaps to limit.
- limit == 0: up with sat=0 produces a tc pulse on every enabled edge and count stays 0.
- limit with a digit > 9 is illegal. Comparisons use a magnitude compare that treats it as binary; the verifier flags it as an assertion, not a functional case.
- Reset mid-count: takes effect immediately; any pending tc or err is cleared.
- Counting never produces a non-BCD digit.
- Cascade use: tc of stage k drives en of stage k+1, so the next stage advances one cycle late. Consumers that need same-cycle ripple use at_limit & en.

Decomposition:
- Package bcd_pkg:
  - localparam DIGIT_W = 4 and DIGIT_MAX = 4'd9.
  - Function is_bcd(vector) returning a valid-digit flag.
  - Function to_bcd(integer, digits) used for INIT.
  - Typedef bcd_digit_t.
- Sub-module bcd_digit_cell: one digit with +1/-1 and carry/borrow in and out, instantiated DIGITS times in a generate chain. The top level holds the register, the compare, and mode selection.

Test Plan:
- DIGITS=2, INIT=5: assert rst mid-simulation -> count = 8'h05 immediately (asynchronous), tc = 0, err = 0.
- limit=8'h23, up=1, sat=0, en held: 8'h21, 8'h22, 8'h23, 8'h00 -> tc high for exactly the cycle count=8'h00; 8'h09 -> 8'h10 carry checked.
- up=0, sat=0, limit=8'h59, count=8'h00, one enable -> count = 8'h59, tc pulses; 8'h10 -> 8'h09 borrow checked.
- sat=1, limit=8'h12, count=8'h12, up=1 for 3 enables -> count stays 8'h12 and tc never asserts; down from 8'h00 stays 8'h00.
- load with load_val=8'h3A -> count unchanged and err pulses once; load 8'h40 with limit=8'h30 -> count = 8'h30; load and en together -> load wins.
- count=8'h45, limit changed to 8'h20: an up step gives 8'h00 with tc; a down step gives 8'h20.
